jtag_tap_target: RTL and testbench

Target-side JTAG test access port, sitting directly downstream of the JTAG host bus. Samples `tck`/`tms`/`tdi`/`trst` in the `clk` domain and runs the IEEE 1149.1 16-state TAP state machine. Owns the instruction register and a parallel-load data register, and drives `tdo` back to the host. Presents capture/update strobes to the on-chip debug controller.

---
 rtl/jtag_tap_target.sv | 220 ++++++++++++++++++++++
 tb/tb_jtag_tap_target.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_target.sv
// Target-side JTAG TAP: samples the host's tck/tms/tdi/trst in the clk domain and runs the
// 1149.1 state machine. It owns the IR and a parallel-load DR and strobes the debug controller.
module jtag_tap_target #(
    parameter int unsigned             IR_WIDTH     = 4,
    parameter int unsigned             DR_WIDTH     = 32,
    parameter logic [DR_WIDTH-1:0]     IDCODE_VALUE = DR_WIDTH'(32'h4e797a69),
    parameter logic [IR_WIDTH-1:0]     IDCODE_INST  = IR_WIDTH'(4'h1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                jtag_tck,
    input  logic                jtag_tms,
    input  logic                jtag_tdi,
    input  logic                jtag_trst,
    output logic                jtag_tdo,
    output logic [IR_WIDTH-1:0] instruction,
    input  logic [DR_WIDTH-1:0] dr_capture_val,
    output logic                dr_capture,
    output logic                dr_update,
    output logic [DR_WIDTH-1:0] dr_update_val
);

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR        = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT1_DR         = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT2_DR         = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR        = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT1_IR         = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT2_IR         = 4'd14,
        UPDATE_IR        = 4'd15
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] BYPASS_INST = {IR_WIDTH{1'b1}};

    logic tck_s1_q, tck_s2_q, tck_d3_q;
    logic tms_s1_q, tms_s2_q;
    logic tdi_s1_q, tdi_s2_q;
    logic trst_s1_q, trst_s2_q;
    logic tck_rise_s, tck_fall_s;

    tap_state_e state_q, state_d;

    logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
    logic [IR_WIDTH-1:0] instruction_q, instruction_d;
    logic [DR_WIDTH-1:0] dr_shift_q, dr_shift_d;
    logic [DR_WIDTH-1:0] dr_update_val_q, dr_update_val_d;
    logic                tdo_q, tdo_d;
    logic                dr_capture_q, dr_capture_d;
    logic                dr_update_q, dr_update_d;
    logic                is_idcode_s, is_bypass_s;

    // Two-flop synchronizers of equal depth, plus a third tck flop for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tck_s1_q  <= 1'b0;
            tck_s2_q  <= 1'b0;
            tck_d3_q  <= 1'b0;
            tms_s1_q  <= 1'b0;
            tms_s2_q  <= 1'b0;
            tdi_s1_q  <= 1'b0;
            tdi_s2_q  <= 1'b0;
            trst_s1_q <= 1'b0;
            trst_s2_q <= 1'b0;
        end else begin
            tck_s1_q  <= jtag_tck;
            tck_s2_q  <= tck_s1_q;
            tck_d3_q  <= tck_s2_q;
            tms_s1_q  <= jtag_tms;
            tms_s2_q  <= tms_s1_q;
            tdi_s1_q  <= jtag_tdi;
            tdi_s2_q  <= tdi_s1_q;
            trst_s1_q <= jtag_trst;
            trst_s2_q <= trst_s1_q;
        end
    end

    assign tck_rise_s  = tck_s2_q & ~tck_d3_q;
    assign tck_fall_s  = ~tck_s2_q & tck_d3_q;
    assign is_idcode_s = (instruction_q == IDCODE_INST);
    assign is_bypass_s = (instruction_q == BYPASS_INST);

    // TAP state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // TAP next-state logic; trst overrides any tck activity in the same cycle.
    always_comb begin
        state_d = state_q;
        if (trst_s2_q) begin
            state_d = TEST_LOGIC_RESET;
        end else if (tck_rise_s) begin
            case (state_q)
                TEST_LOGIC_RESET: state_d = tms_s2_q ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
                RUN_TEST_IDLE:    state_d = tms_s2_q ? SELECT_DR        : RUN_TEST_IDLE;
                SELECT_DR:        state_d = tms_s2_q ? SELECT_IR        : CAPTURE_DR;
                CAPTURE_DR:       state_d = tms_s2_q ? EXIT1_DR         : SHIFT_DR;
                SHIFT_DR:         state_d = tms_s2_q ? EXIT1_DR         : SHIFT_DR;
                EXIT1_DR:         state_d = tms_s2_q ? UPDATE_DR        : PAUSE_DR;
                PAUSE_DR:         state_d = tms_s2_q ? EXIT2_DR         : PAUSE_DR;
                EXIT2_DR:         state_d = tms_s2_q ? UPDATE_DR        : SHIFT_DR;
                UPDATE_DR:        state_d = tms_s2_q ? SELECT_DR        : RUN_TEST_IDLE;
                SELECT_IR:        state_d = tms_s2_q ? TEST_LOGIC_RESET : CAPTURE_IR;
                CAPTURE_IR:       state_d = tms_s2_q ? EXIT1_IR         : SHIFT_IR;
                SHIFT_IR:         state_d = tms_s2_q ? EXIT1_IR         : SHIFT_IR;
                EXIT1_IR:         state_d = tms_s2_q ? UPDATE_IR        : PAUSE_IR;
                PAUSE_IR:         state_d = tms_s2_q ? EXIT2_IR         : PAUSE_IR;
                EXIT2_IR:         state_d = tms_s2_q ? UPDATE_IR        : SHIFT_IR;
                UPDATE_IR:        state_d = tms_s2_q ? SELECT_DR        : RUN_TEST_IDLE;
                default:          state_d = TEST_LOGIC_RESET;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Shift registers, instruction, strobes and tdo; actions key off the pre-transition state.
    always_comb begin
        ir_shift_d      = ir_shift_q;
        dr_shift_d      = dr_shift_q;
        instruction_d   = instruction_q;
        dr_update_val_d = dr_update_val_q;
        tdo_d           = tdo_q;
        dr_capture_d    = 1'b0;
        dr_update_d     = 1'b0;
        if (trst_s2_q) begin
            instruction_d = IDCODE_INST;
        end else if (tck_rise_s) begin
            case (state_q)
                TEST_LOGIC_RESET: instruction_d = IDCODE_INST;
                CAPTURE_IR:       ir_shift_d    = {{(IR_WIDTH-1){1'b0}}, 1'b1};
                SHIFT_IR:         ir_shift_d    = {tdi_s2_q, ir_shift_q[IR_WIDTH-1:1]};
                UPDATE_IR:        instruction_d = ir_shift_q;
                CAPTURE_DR: begin
                    if (is_idcode_s) begin
                        dr_shift_d = IDCODE_VALUE;
                    end else if (is_bypass_s) begin
                        dr_shift_d = {DR_WIDTH{1'b0}};
                    end else begin
                        dr_shift_d   = dr_capture_val;
                        dr_capture_d = 1'b1;
                    end
                end
                SHIFT_DR: begin
                    // BYPASS behaves as a single-bit register living in bit 0.
                    if (is_bypass_s) begin
                        dr_shift_d = {dr_shift_q[DR_WIDTH-1:1], tdi_s2_q};
                    end else begin
                        dr_shift_d = {tdi_s2_q, dr_shift_q[DR_WIDTH-1:1]};
                    end
                end
                UPDATE_DR: begin
                    if (!is_idcode_s && !is_bypass_s) begin
                        dr_update_val_d = dr_shift_q;
                        dr_update_d     = 1'b1;
                    end else begin
                        dr_update_val_d = dr_update_val_q;
                    end
                end
                default: ir_shift_d = ir_shift_q;
            endcase
        end else if (tck_fall_s) begin
            if (state_q == TEST_LOGIC_RESET) begin
                instruction_d = IDCODE_INST;
            end else begin
                instruction_d = instruction_q;
            end
            case (state_q)
                SHIFT_DR: tdo_d = dr_shift_q[0];
                SHIFT_IR: tdo_d = ir_shift_q[0];
                default:  tdo_d = tdo_q;
            endcase
        end else if (state_q == TEST_LOGIC_RESET) begin
            instruction_d = IDCODE_INST;
        end else begin
            instruction_d = instruction_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_shift_q      <= {IR_WIDTH{1'b0}};
            dr_shift_q      <= {DR_WIDTH{1'b0}};
            instruction_q   <= IDCODE_INST;
            dr_update_val_q <= {DR_WIDTH{1'b0}};
            tdo_q           <= 1'b0;
            dr_capture_q    <= 1'b0;
            dr_update_q     <= 1'b0;
        end else begin
            ir_shift_q      <= ir_shift_d;
            dr_shift_q      <= dr_shift_d;
            instruction_q   <= instruction_d;
            dr_update_val_q <= dr_update_val_d;
            tdo_q           <= tdo_d;
            dr_capture_q    <= dr_capture_d;
            dr_update_q     <= dr_update_d;
        end
    end

    assign jtag_tdo      = tdo_q;
    assign instruction   = instruction_q;
    assign dr_capture    = dr_capture_q;
    assign dr_update     = dr_update_q;
    assign dr_update_val = dr_update_val_q;

endmodule

// File: tb/tb_jtag_tap_target.sv
// Scoreboard bench for jtag_tap_target: the driver queues expected tdo bits and strobes,
// independent monitors pop and compare whenever the DUT presents them.
module tb_jtag_tap_target;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        jtag_tck = 1'b0;
    logic        jtag_tms = 1'b0;
    logic        jtag_tdi = 1'b0;
    logic        jtag_trst = 1'b0;
    logic        jtag_tdo;
    logic [3:0]  instruction;
    logic [31:0] dr_capture_val = 32'h0;
    logic        dr_capture;
    logic        dr_update;
    logic [31:0] dr_update_val;

    int checks = 0;
    int errors = 0;

    logic        exp_tdo_q[$];
    int          exp_cap_q[$];
    logic [31:0] exp_upd_q[$];
    string       tdo_tag;
    event        tdo_ev;

    jtag_tap_target dut (
        .clk            (clk),
        .reset          (reset),
        .jtag_tck       (jtag_tck),
        .jtag_tms       (jtag_tms),
        .jtag_tdi       (jtag_tdi),
        .jtag_trst      (jtag_trst),
        .jtag_tdo       (jtag_tdo),
        .instruction    (instruction),
        .dr_capture_val (dr_capture_val),
        .dr_capture     (dr_capture),
        .dr_update      (dr_update),
        .dr_update_val  (dr_update_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // One full tck period, 8 clk high then 8 clk low.
    task automatic tck_cyc(input logic tms, input logic tdi);
        jtag_tms = tms;
        jtag_tdi = tdi;
        jtag_tck = 1'b1;
        repeat (8) @(negedge clk);
        jtag_tck = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic sample_tdo(input logic exp);
        exp_tdo_q.push_back(exp);
        -> tdo_ev;
    endtask

    // From Run-Test/Idle: load an IR value, checking the captured shift-out; ends in idle.
    task automatic ir_scan(input logic [3:0] val, input logic [3:0] exp_out);
        tdo_tag = "ir_tdo";
        tck_cyc(1'b1, 1'b0);
        tck_cyc(1'b1, 1'b0);
        tck_cyc(1'b0, 1'b0);
        tck_cyc(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sample_tdo(exp_out[i]);
            tck_cyc(i == 3, val[i]);
        end
        tck_cyc(1'b1, 1'b0);
        tck_cyc(1'b0, 1'b0);
    endtask

    // From Run-Test/Idle: enter Shift-DR and shift n bits, checking tdo; optionally finish the scan.
    task automatic dr_scan(input int n, input logic [31:0] din, input logic [31:0] exp_out,
                           input logic complete);
        logic last;
        tdo_tag = "dr_tdo";
        tck_cyc(1'b1, 1'b0);
        tck_cyc(1'b0, 1'b0);
        tck_cyc(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            last = complete && (i == n - 1);
            sample_tdo(exp_out[i]);
            tck_cyc(last, din[i]);
        end
        if (complete) begin
            tck_cyc(1'b1, 1'b0);
            tck_cyc(1'b0, 1'b0);
        end
    endtask

    // tdo monitor: compares whenever the driver announces a tdo sample point.
    initial begin
        logic e;
        forever begin
            @(tdo_ev);
            checks++;
            if (exp_tdo_q.size() == 0) begin
                errors++;
                $display("FAIL %s no expected bit queued got=%0b", tdo_tag, jtag_tdo);
            end else begin
                e = exp_tdo_q.pop_front();
                if (jtag_tdo !== e) begin
                    errors++;
                    $display("FAIL %s got=%0b exp=%0b", tdo_tag, jtag_tdo, e);
                end
            end
        end
    end

    // Strobe monitor: every dr_capture/dr_update cycle must match a queued expectation.
    initial begin
        logic [31:0] ev;
        forever begin
            @(negedge clk);
            if (dr_capture === 1'b1) begin
                checks++;
                if (exp_cap_q.size() == 0) begin
                    errors++;
                    $display("FAIL dr_capture unexpected got=1 exp=0");
                end else begin
                    void'(exp_cap_q.pop_front());
                end
            end
            if (dr_update === 1'b1) begin
                checks++;
                if (exp_upd_q.size() == 0) begin
                    errors++;
                    $display("FAIL dr_update unexpected got=1 exp=0 val=%0h", dr_update_val);
                end else begin
                    ev = exp_upd_q.pop_front();
                    if (dr_update_val !== ev) begin
                        errors++;
                        $display("FAIL dr_update_val got=%0h exp=%0h", dr_update_val, ev);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_instruction", 64'(instruction), 64'h1);
        check("rst_tdo", 64'(jtag_tdo), 64'h0);
        check("rst_dr_capture", 64'(dr_capture), 64'h0);
        check("rst_dr_update", 64'(dr_update), 64'h0);
        check("rst_dr_update_val", 64'(dr_update_val), 64'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 10; i++) tck_cyc(1'b0, 1'b0);
        check("idle_instruction", 64'(instruction), 64'h1);
        check("idle_tdo", 64'(jtag_tdo), 64'h0);

        // IDCODE read, no strobes expected.
        dr_scan(32, 32'h0, 32'h4e797a69, 1'b1);
        check("idcode_instruction", 64'(instruction), 64'h1);

        // User DR scan through instruction 2.
        ir_scan(4'h2, 4'b0001);
        check("user_instruction", 64'(instruction), 64'h2);
        dr_capture_val = 32'hDEADBEEF;
        exp_cap_q.push_back(1);
        exp_upd_q.push_back(32'h12345678);
        dr_scan(32, 32'h12345678, 32'hDEADBEEF, 1'b1);
        check("user_update_val_held", 64'(dr_update_val), 64'h12345678);

        // BYPASS: one-bit delay, no update.
        ir_scan(4'hF, 4'b0001);
        check("bypass_instruction", 64'(instruction), 64'hF);
        dr_scan(4, 32'b1101, 32'b1010, 1'b1);

        // Five tms=1 rises from Shift-DR reach Test-Logic-Reset.
        dr_scan(2, 32'b11, 32'b10, 1'b0);
        for (int i = 0; i < 5; i++) tck_cyc(1'b1, 1'b0);
        check("tms_reset_instruction", 64'(instruction), 64'h1);
        tck_cyc(1'b0, 1'b0);

        // trst pulse in the middle of an IR scan.
        ir_scan(4'h2, 4'b0001);
        check("pre_trst_instruction", 64'(instruction), 64'h2);
        tck_cyc(1'b1, 1'b0);
        tck_cyc(1'b1, 1'b0);
        tck_cyc(1'b0, 1'b0);
        tck_cyc(1'b0, 1'b0);
        tck_cyc(1'b0, 1'b1);
        tck_cyc(1'b0, 1'b1);
        jtag_trst = 1'b1;
        repeat (6) @(negedge clk);
        check("trst_instruction", 64'(instruction), 64'h1);
        jtag_trst = 1'b0;
        repeat (4) @(negedge clk);
        tck_cyc(1'b0, 1'b0);
        check("post_trst_instruction", 64'(instruction), 64'h1);

        // Asynchronous reset after 10 of 32 user DR bits.
        ir_scan(4'h2, 4'b0001);
        exp_cap_q.push_back(2);
        dr_scan(10, 32'h3FF, 32'hDEADBEEF, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("async_instruction", 64'(instruction), 64'h1);
        check("async_tdo", 64'(jtag_tdo), 64'h0);
        check("async_dr_update_val", 64'(dr_update_val), 64'h0);
        check("async_dr_update", 64'(dr_update), 64'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        tck_cyc(1'b0, 1'b0);
        ir_scan(4'h2, 4'b0001);
        dr_capture_val = 32'hCAFEF00D;
        exp_cap_q.push_back(3);
        exp_upd_q.push_back(32'hA5A50F0F);
        dr_scan(32, 32'hA5A50F0F, 32'hCAFEF00D, 1'b1);

        repeat (8) @(negedge clk);
        check("tdo_queue_drained", 64'(exp_tdo_q.size()), 64'h0);
        check("capture_queue_drained", 64'(exp_cap_q.size()), 64'h0);
        check("update_queue_drained", 64'(exp_upd_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
